avg_fetch_exec: RTL and testbench

//  Sequential successor to the combinational AVG decoder: fetches AVG vector-list instructions from
//  16-bit vector memory, assembles 2/4-byte instructions, executes JMP/JSR/RTS internally on a

---
 rtl/avg_fetch_exec.sv | 242 ++++++++++++++++++++++++
 tb/tb_avg_fetch_exec.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avg_fetch_exec.sv
// AVG vector-list fetch/execute engine: fetches 2/4-byte instructions from 16-bit vector memory,
// runs JMP/JSR/RTS on an internal return stack and hands decoded draw commands out over valid/ready.
module avg_fetch_exec #(
  parameter int          ADDR_W      = 13,
  parameter int          COORD_W     = 16,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned START_ADDR  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic               busy,
  output logic               err,
  output logic               mem_rd,
  output logic [ADDR_W-2:0]  mem_addr,
  input  logic [15:0]        mem_rdata,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [2:0]         cmd_type,
  output logic [COORD_W-1:0] dx,
  output logic [COORD_W-1:0] dy,
  output logic               blank,
  output logic               use_zreg,
  output logic [7:0]         z_val,
  output logic [3:0]         color,
  output logic [7:0]         lin_scale,
  output logic [2:0]         bin_scale
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [ADDR_W-1:0] START_PC = START_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LEN2     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] LEN4     = ADDR_W'(4);
  localparam logic [ADDR_W-2:0] WORD_ONE = (ADDR_W-1)'(1);
  localparam logic [SP_W-1:0]   SP_FULL  = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]   SP_ONE   = SP_W'(1);

  localparam logic [2:0] OP_VCTR = 3'd0, OP_HALT = 3'd1, OP_SVEC = 3'd2, OP_STSC = 3'd3,
                         OP_CNTR = 3'd4, OP_JSR  = 3'd5, OP_RTS  = 3'd6, OP_JMP  = 3'd7;
  localparam logic [2:0] CMD_VEC = 3'd0, CMD_STAT = 3'd1, CMD_SCAL = 3'd2,
                         CMD_CNTR = 3'd3, CMD_HALT = 3'd4;

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_W0, S_RD1, S_W1, S_EXEC, S_OUT, S_ERR} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, pc_inc, jmp_target, pop_addr;
  logic [SP_W-1:0]   sp, sp_d, sp_dec;
  logic              err_d, push, load_cmd, clr_cmd;
  logic [7:0]        b0, b1, b2, b3;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [2:0]         dec_type, code;
  logic [COORD_W-1:0] dec_dx, dec_dy;
  logic               dec_blank, dec_zreg, is_vec;
  logic [7:0]         dec_z, dec_lin;
  logic [3:0]         dec_color;
  logic [2:0]         dec_bin;

  function automatic logic [COORD_W-1:0] sext13(input logic [12:0] v);
    return COORD_W'($signed(v));
  endfunction

  assign opcode     = b1[7:5];
  assign pc_inc     = pc + ((opcode == OP_VCTR) ? LEN4 : LEN2);
  assign jmp_target = ADDR_W'({b1[3:0], b0, 1'b0});
  assign sp_dec     = sp - SP_ONE;
  assign pop_addr   = stack[sp_dec[IDX_W-1:0]];

  assign busy      = (state != S_IDLE) && (state != S_ERR);
  assign cmd_valid = (state == S_OUT);
  assign mem_rd    = (state == S_RD0) || (state == S_RD1);
  assign mem_addr  = (state == S_RD0) ? pc[ADDR_W-1:1] :
                     (state == S_RD1) ? pc[ADDR_W-1:1] + WORD_ONE : '0;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred on any path.
    state_d  = state;
    pc_d     = pc;
    sp_d     = sp;
    err_d    = err;
    push     = 1'b0;
    load_cmd = 1'b0;
    clr_cmd  = 1'b0;
    case (state)
      S_IDLE, S_ERR: if (go) begin
        state_d = S_RD0;
        pc_d    = START_PC;
        sp_d    = '0;
        err_d   = 1'b0;
      end
      S_RD0: state_d = S_W0;
      S_W0:  state_d = (mem_rdata[15:13] == OP_VCTR) ? S_RD1 : S_EXEC;
      S_RD1: state_d = S_W1;
      S_W1:  state_d = S_EXEC;
      S_EXEC: begin
        pc_d    = pc_inc;
        state_d = S_RD0;
        case (opcode)
          OP_JMP: pc_d = jmp_target;
          OP_JSR: if (sp == SP_FULL) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            push = 1'b1;
            sp_d = sp + SP_ONE;
            pc_d = jmp_target;
          end
          OP_RTS: if (sp == '0) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            sp_d = sp_dec;
            pc_d = pop_addr;
          end
          default: begin
            load_cmd = 1'b1;
            state_d  = S_OUT;
          end
        endcase
      end
      S_OUT: if (cmd_ready) begin
        clr_cmd = 1'b1;
        state_d = (cmd_type == CMD_HALT) ? S_IDLE : S_RD0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Payload decode from the latched instruction bytes; only consumed when load_cmd is high.
  always_comb begin
    dec_type  = CMD_VEC;
    dec_dx    = '0;
    dec_dy    = '0;
    dec_blank = 1'b0;
    dec_zreg  = 1'b0;
    dec_z     = '0;
    dec_color = '0;
    dec_lin   = '0;
    dec_bin   = '0;
    code      = '0;
    is_vec    = 1'b0;
    case (opcode)
      OP_VCTR: begin
        is_vec = 1'b1;
        dec_dy = sext13({b1[4:0], b0});
        dec_dx = sext13({b3[4:0], b2});
        code   = b3[7:5];
      end
      OP_SVEC: begin
        is_vec = 1'b1;
        dec_dy = sext13({{7{b1[4]}}, b1[4:0], 1'b0});
        dec_dx = sext13({{7{b0[4]}}, b0[4:0], 1'b0});
        code   = b0[7:5];
      end
      OP_STSC: if (b1[4]) begin
        dec_type = CMD_SCAL;
        dec_lin  = b0;
        dec_bin  = b1[2:0];
      end else begin
        dec_type  = CMD_STAT;
        dec_z     = b0;
        dec_color = b1[3:0];
      end
      OP_CNTR: dec_type = CMD_CNTR;
      OP_HALT: dec_type = CMD_HALT;
      default: dec_type = CMD_VEC;
    endcase
    if (is_vec) begin
      case (code)
        3'd0:    dec_blank = 1'b1;
        3'd1:    dec_zreg  = 1'b1;
        default: dec_z     = {4'b0, code, 1'b0};
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= START_PC;
      sp        <= '0;
      err       <= 1'b0;
      b0        <= '0;
      b1        <= '0;
      b2        <= '0;
      b3        <= '0;
      cmd_type  <= '0;
      dx        <= '0;
      dy        <= '0;
      blank     <= 1'b0;
      use_zreg  <= 1'b0;
      z_val     <= '0;
      color     <= '0;
      lin_scale <= '0;
      bin_scale <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      sp    <= sp_d;
      err   <= err_d;
      if (state == S_W0) begin
        b0 <= mem_rdata[7:0];
        b1 <= mem_rdata[15:8];
      end
      if (state == S_W1) begin
        b2 <= mem_rdata[7:0];
        b3 <= mem_rdata[15:8];
      end
      if (load_cmd) begin
        cmd_type  <= dec_type;
        dx        <= dec_dx;
        dy        <= dec_dy;
        blank     <= dec_blank;
        use_zreg  <= dec_zreg;
        z_val     <= dec_z;
        color     <= dec_color;
        lin_scale <= dec_lin;
        bin_scale <= dec_bin;
      end else if (clr_cmd) begin
        cmd_type  <= '0;
        dx        <= '0;
        dy        <= '0;
        blank     <= 1'b0;
        use_zreg  <= 1'b0;
        z_val     <= '0;
        color     <= '0;
        lin_scale <= '0;
        bin_scale <= '0;
      end
    end
  end

  // NOTE: the return stack has no reset; sp alone marks live entries, so stale words are never read.
  always_ff @(posedge clk) begin
    if (push) stack[sp[IDX_W-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_avg_fetch_exec.sv
// Directed bench for avg_fetch_exec: table of single-instruction lists plus hand-written
// sequences for backpressure, subroutine calls, stack errors and mid-fetch reset.
module tb_avg_fetch_exec;

  logic        clk = 1'b0;
  logic        rst, go, cmd_ready;
  logic        busy, err, mem_rd, cmd_valid, blank, use_zreg;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0000;
  logic [2:0]  cmd_type, bin_scale;
  logic [15:0] dx, dy;
  logic [7:0]  z_val, lin_scale;
  logic [3:0]  color;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [4096];
  int          rd_count = 0;
  logic [11:0] last_addr = '0;
  int          rd0;

  avg_fetch_exec dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .err(err),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .dx(dx), .dy(dy), .blank(blank), .use_zreg(use_zreg), .z_val(z_val),
    .color(color), .lin_scale(lin_scale), .bin_scale(bin_scale)
  );

  always #5 clk = ~clk;

  // Vector memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_count  <= rd_count + 1;
      last_addr <= mem_addr;
    end
  end

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [2:0]  typ;
    logic [15:0] dx, dy;
    logic        blank, zreg;
    logic [7:0]  z;
    logic [3:0]  color;
    logic [7:0]  lin;
    logic [2:0]  bin;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic pulse_go;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!cmd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, cmd_valid, 1);
  endtask

  task automatic wait_err(input string name);
    int n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, err, 1);
  endtask

  task automatic accept;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    go = 1'b0;
    cmd_ready = 1'b0;
    clear_mem();

    //                b0     b1     b2     b3     typ   dx        dy        bl    zr    z      col   lin    bin
    vecs[0] = '{8'h40, 8'h72, 8'h00, 8'h00, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 8'h40, 3'd2};
    vecs[1] = '{8'h10, 8'h1F, 8'h20, 8'hE0, 3'd0, 16'h0020, 16'hFF10, 1'b0, 1'b0, 8'h0E, 4'h0, 8'h00, 3'd0};
    vecs[2] = '{8'h3F, 8'h5E, 8'h00, 8'h00, 3'd0, 16'hFFFE, 16'hFFFC, 1'b0, 1'b1, 8'h00, 4'h0, 8'h00, 3'd0};
    vecs[3] = '{8'hA5, 8'h6C, 8'h00, 8'h00, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'hA5, 4'hC, 8'h00, 3'd0};
    vecs[4] = '{8'h00, 8'h80, 8'h00, 8'h00, 3'd3, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0};
    vecs[5] = '{8'h05, 8'h00, 8'hFF, 8'h1F, 3'd0, 16'hFFFF, 16'h0005, 1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 3'd0};
    vecs[6] = '{8'hA3, 8'h4A, 8'h00, 8'h00, 3'd0, 16'h0006, 16'h0014, 1'b0, 1'b0, 8'h0A, 4'h0, 8'h00, 3'd0};

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_type", cmd_type, 0);
    check("rst_dx", dx, 0);
    rst = 1'b0;

    // Each list: one instruction then HALT right after it (zero-filled memory elsewhere).
    for (int i = 0; i < 7; i++) begin
      clear_mem();
      mem[0] = {vecs[i].b1, vecs[i].b0};
      if (vecs[i].b1[7:5] == 3'd0) begin
        mem[1] = {vecs[i].b3, vecs[i].b2};
        mem[2] = 16'h2000;
      end else begin
        mem[1] = 16'h2000;
      end
      pulse_go();
      check($sformatf("v%0d_first_rd", i), mem_rd, 1);
      check($sformatf("v%0d_first_addr", i), mem_addr, 0);
      wait_valid($sformatf("v%0d_valid", i));
      check($sformatf("v%0d_type", i), cmd_type, vecs[i].typ);
      check($sformatf("v%0d_dx", i), dx, vecs[i].dx);
      check($sformatf("v%0d_dy", i), dy, vecs[i].dy);
      check($sformatf("v%0d_blank", i), blank, vecs[i].blank);
      check($sformatf("v%0d_zreg", i), use_zreg, vecs[i].zreg);
      check($sformatf("v%0d_z", i), z_val, vecs[i].z);
      check($sformatf("v%0d_color", i), color, vecs[i].color);
      check($sformatf("v%0d_lin", i), lin_scale, vecs[i].lin);
      check($sformatf("v%0d_bin", i), bin_scale, vecs[i].bin);
      accept();
      wait_valid($sformatf("v%0d_halt_valid", i));
      check($sformatf("v%0d_halt_type", i), cmd_type, 4);
      accept();
      check($sformatf("v%0d_busy_after", i), busy, 0);
    end

    // Backpressure: payload holds, no fetch, and a go pulse while busy is ignored.
    clear_mem();
    mem[0] = 16'h5E3F;
    mem[1] = 16'h2000;
    pulse_go();
    wait_valid("stall_valid");
    rd0 = rd_count;
    for (int k = 0; k < 5; k++) begin
      go = (k == 2);
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), cmd_valid, 1);
      check($sformatf("stall%0d_dy", k), dy, 16'hFFFC);
      check($sformatf("stall%0d_dx", k), dx, 16'hFFFE);
      check($sformatf("stall%0d_mem_rd", k), mem_rd, 0);
    end
    go = 1'b0;
    check("stall_no_reads", rd_count - rd0, 0);
    accept();
    wait_valid("stall_halt_valid");
    check("stall_halt_type", cmd_type, 4);
    accept();

    // JSR to word 0x100 (CNTR; RTS), then HALT back at the caller.
    clear_mem();
    mem[0]     = 16'hA100;
    mem[1]     = 16'h2000;
    mem[12'h100] = 16'h8000;
    mem[12'h101] = 16'hC000;
    rd0 = rd_count;
    pulse_go();
    wait_valid("jsr_cntr_valid");
    check("jsr_cntr_type", cmd_type, 3);
    check("jsr_sub_addr", last_addr, 12'h100);
    accept();
    wait_valid("jsr_halt_valid");
    check("jsr_halt_type", cmd_type, 4);
    check("jsr_return_addr", last_addr, 12'h001);
    check("jsr_fetch_count", rd_count - rd0, 4);
    accept();
    check("jsr_busy_after", busy, 0);

    // Self-calling JSR: the fifth call overflows the 4-entry stack.
    clear_mem();
    mem[0] = 16'hA000;
    rd0 = rd_count;
    pulse_go();
    wait_err("ovf_err");
    check("ovf_busy", busy, 0);
    check("ovf_fetch_count", rd_count - rd0, 5);
    repeat (10) @(negedge clk);
    check("ovf_no_more_reads", rd_count - rd0, 5);
    check("ovf_cmd_valid", cmd_valid, 0);
    check("ovf_err_sticky", err, 1);
    mem[0] = 16'h2000;
    pulse_go();
    check("ovf_go_clears_err", err, 0);
    check("ovf_restart_rd", mem_rd, 1);
    check("ovf_restart_addr", mem_addr, 0);
    wait_valid("ovf_halt_valid");
    check("ovf_halt_type", cmd_type, 4);
    accept();

    // RTS with an empty stack.
    clear_mem();
    mem[0] = 16'hC000;
    rd0 = rd_count;
    pulse_go();
    wait_err("rts_err");
    check("rts_busy", busy, 0);
    check("rts_fetch_count", rd_count - rd0, 1);

    // Reset while waiting for the second half of a VCTR.
    mem[0] = 16'h1F10;
    mem[1] = 16'hE020;
    pulse_go();
    check("rw_err_cleared", err, 0);
    @(negedge clk);
    @(negedge clk);
    check("rw_rd1_strobe", mem_rd, 1);
    check("rw_rd1_addr", mem_addr, 1);
    @(negedge clk);
    check("rw_busy_in_w1", busy, 1);
    rst = 1'b1;
    #1;
    check("rw_busy", busy, 0);
    check("rw_mem_rd", mem_rd, 0);
    check("rw_cmd_valid", cmd_valid, 0);
    check("rw_err", err, 0);
    check("rw_cmd_type", cmd_type, 0);
    @(negedge clk);
    rst = 1'b0;
    rd0 = rd_count;
    repeat (5) @(negedge clk);
    check("rw_idle_busy", busy, 0);
    check("rw_idle_no_reads", rd_count - rd0, 0);
    check("rw_idle_valid", cmd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
